// File: rtl/student_id_pkg.sv
// Shared types and constants for the student ID sender.
// The ID string, its length and the debounce window all live here so the
// top and the trigger front end agree on them.
package student_id_pkg;

  localparam int ID_LEN          = 10;
  localparam int IDX_W           = $clog2(ID_LEN);
  localparam int DEBOUNCE_CYCLES = 16;

  localparam logic [ID_LEN*8-1:0] ID_STR_DEFAULT = "2024311668";

  typedef logic [7:0] ascii_t;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_BUSY,
    WAIT_READY
  } state_e;

  // Character 0 is the leftmost (most significant) byte of the string.
  function automatic ascii_t id_char(input logic [ID_LEN*8-1:0] str,
                                     input logic [IDX_W-1:0]    idx);
    id_char = str[(ID_LEN - 1 - int'(idx)) * 8 +: 8];
  endfunction

endpackage

// File: rtl/trigger_debounce.sv
// Trigger front end: input register, optional debouncer, rising-edge detector.
// Build macro: TRIG_DEBOUNCE_EN adds a counter-based debouncer that needs
// DEBOUNCE_CYCLES consecutive equal samples before the internal level moves.
// Without the macro the registered raw trigger feeds the edge detector.
module trigger_debounce
  import student_id_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic trigger_i,
  output logic start_o
);

  logic syncQ;
  logic level;
  logic prevQ;
  logic armedQ;

  // Input register tracks the button even during reset, so a trigger that is
  // already held when reset releases is never mistaken for a fresh press.
  always_ff @(posedge clk) begin
    syncQ <= trigger_i;
  end

`ifdef TRIG_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic [CNT_W-1:0] cntQ;
  logic             levelQ;

  // The level only follows the input once it has disagreed for a full window.
  always_ff @(posedge clk) begin
    if (rst) begin
      levelQ <= 1'b0;
      cntQ   <= '0;
    end else if (syncQ == levelQ) begin
      cntQ <= '0;
    end else if (cntQ == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      levelQ <= syncQ;
      cntQ   <= '0;
    end else begin
      cntQ <= cntQ + 1'b1;
    end
  end

  assign level = levelQ;
`else
  assign level = syncQ;
`endif

  // Edge register, plus an arm flag that requires a low trigger after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      prevQ  <= 1'b0;
      armedQ <= 1'b0;
    end else begin
      prevQ  <= level;
      armedQ <= armedQ | ~syncQ;
    end
  end

  assign start_o = level & ~prevQ & armedQ;

endmodule

// File: rtl/student_id_sender.sv
// Sends the ASCII student ID one byte at a time to uart_send per trigger press.
// Each byte is offered with a one-cycle tx_valid strobe while uart_ready is
// high, then the sender waits for uart_send to go busy and come back idle.
// Build macro: TRIG_DEBOUNCE_EN enables the trigger debouncer, adding
// DEBOUNCE_CYCLES cycles of start latency.
module student_id_sender
  import student_id_pkg::*;
#(
  parameter logic [ID_LEN*8-1:0] ID_STR = ID_STR_DEFAULT
)
(
  input  logic       clk,
  input  logic       rst,
  input  logic       trigger,
  input  logic       uart_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ID_LEN - 1);

  logic             start;
  state_e           stateQ;
  logic [IDX_W-1:0] indexQ;
  ascii_t           txDataQ;
  logic             txValidQ;

  trigger_debounce uTrigger (
    .clk       (clk),
    .rst       (rst),
    .trigger_i (trigger),
    .start_o   (start)
  );

  // Sender FSM; strobe defaults low so it can never last two cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ   <= IDLE;
      indexQ   <= '0;
      txValidQ <= 1'b0;
      txDataQ  <= 8'h00;
    end else begin
      txValidQ <= 1'b0;
      case (stateQ)
        IDLE: begin
          if (start) begin
            indexQ <= '0;
            stateQ <= SEND;
          end
        end
        SEND: begin
          if (uart_ready) begin
            txValidQ <= 1'b1;
            txDataQ  <= id_char(ID_STR, indexQ);
            stateQ   <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (!uart_ready) begin
            stateQ <= WAIT_READY;
          end
        end
        WAIT_READY: begin
          if (uart_ready) begin
            if (indexQ == LAST_IDX) begin
              stateQ <= IDLE;
            end else begin
              indexQ <= indexQ + 1'b1;
              stateQ <= SEND;
            end
          end
        end
        default: begin
          stateQ <= IDLE;
        end
      endcase
    end
  end

  assign tx_data  = txDataQ;
  assign tx_valid = txValidQ;

endmodule

// File: tb/tb_student_id_sender.sv
// Bench for student_id_sender with a uart_send ready/busy model and a byte
// scoreboard. Build macro TRIG_DEBOUNCE_EN selects the debounced timing.
module tb_student_id_sender;

  logic       clk        = 1'b0;
  logic       rst        = 1'b1;
  logic       trigger    = 1'b1;
  logic       uart_ready = 1'b1;
  logic [7:0] tx_data;
  logic       tx_valid;

  int   errors     = 0;
  int   checks     = 0;
  int   pulseCount = 0;
  int   busyLen    = 3;
  int   busyCnt    = 0;
  logic prevValid  = 1'b0;

  logic [7:0] expQ [$];
  logic [7:0] idBytes [10] = '{8'h32, 8'h30, 8'h32, 8'h34, 8'h33,
                               8'h31, 8'h31, 8'h36, 8'h36, 8'h38};

`ifdef TRIG_DEBOUNCE_EN
  localparam int LAT = 18;
`else
  localparam int LAT = 2;
`endif

  student_id_sender dut (
    .clk        (clk),
    .rst        (rst),
    .trigger    (trigger),
    .uart_ready (uart_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // uart_send model: busy from the cycle after an accepted byte for busyLen cycles.
  always @(posedge clk) begin
    if (tx_valid && uart_ready) begin
      uart_ready <= 1'b0;
      busyCnt    <= busyLen;
    end else if (!uart_ready) begin
      if (busyCnt <= 1) uart_ready <= 1'b1;
      busyCnt <= busyCnt - 1;
    end
  end

  // Output monitor: every strobe must be expected, legal and carry the right byte.
  always @(negedge clk) begin
    if (tx_valid) begin
      checkOutput("ready_at_valid", 32'(uart_ready), 32'd1);
      checkOutput("no_back_to_back", 32'(prevValid), 32'd0);
      checkOutput("pulse_expected", 32'(expQ.size() != 0), 32'd1);
      if (expQ.size() != 0) checkOutput("tx_data", 32'(tx_data), 32'(expQ.pop_front()));
      pulseCount++;
    end
    prevValid = tx_valid;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic trig, input logic rstVal);
    trigger = trig;
    rst     = rstVal;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pushId();
    for (int i = 0; i < 10; i++) expQ.push_back(idBytes[i]);
  endtask

  task automatic waitPulses(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (pulseCount >= target) break;
    end
  endtask

  task automatic measureLatency(output int k);
    k = 0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (tx_valid) begin
        k = i;
        break;
      end
    end
  endtask

  int base;
  int lat;

  initial begin
    $display("[TB] start, expected first-strobe latency %0d cycles", LAT);

    // Reset held with trigger high: outputs quiet, no send after release.
    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("reset_valid", 32'(tx_valid), 32'd0);
      checkOutput("reset_data", 32'(tx_data), 32'h00);
    end
    @(posedge clk);
    #1;
    base = pulseCount;
    applyStimulus(1'b1, 1'b0);
    tick(60);
    checkOutput("no_send_after_reset", 32'(pulseCount - base), 32'd0);

    // Held trigger: one transmission, check first-strobe latency.
    applyStimulus(1'b0, 1'b0);
    tick(40);
    base = pulseCount;
    applyStimulus(1'b1, 1'b0);
    pushId();
    measureLatency(lat);
    checkOutput("first_latency", 32'(lat), 32'(LAT + 1));
    tick(100);
    applyStimulus(1'b0, 1'b0);
    waitPulses(base + 10, 2000);
    tick(40);
    checkOutput("held_count", 32'(pulseCount - base), 32'd10);
    checkOutput("held_drained", 32'(expQ.size()), 32'd0);

    // Slow uart_send: 50 busy cycles per byte.
    busyLen = 50;
    tick(40);
    base = pulseCount;
    applyStimulus(1'b1, 1'b0);
    pushId();
    tick(40);
    applyStimulus(1'b0, 1'b0);
    waitPulses(base + 10, 3000);
    tick(60);
    checkOutput("slow_count", 32'(pulseCount - base), 32'd10);
    checkOutput("slow_drained", 32'(expQ.size()), 32'd0);

    // Second trigger edge during byte 4 is ignored.
    busyLen = 10;
    tick(40);
    base = pulseCount;
    applyStimulus(1'b1, 1'b0);
    pushId();
    waitPulses(base + 4, 500);
    applyStimulus(1'b0, 1'b0);
    tick(3);
    applyStimulus(1'b1, 1'b0);
    tick(30);
    applyStimulus(1'b0, 1'b0);
    waitPulses(base + 10, 1000);
    tick(100);
    checkOutput("retrig_count", 32'(pulseCount - base), 32'd10);
    checkOutput("retrig_drained", 32'(expQ.size()), 32'd0);

    // Reset after byte 5 aborts; next press restarts from character 0.
    tick(40);
    base = pulseCount;
    applyStimulus(1'b1, 1'b0);
    pushId();
    waitPulses(base + 5, 500);
    applyStimulus(1'b1, 1'b1);
    expQ.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("abort_valid", 32'(tx_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b0);
    tick(40);
    checkOutput("abort_count", 32'(pulseCount - base), 32'd5);
    applyStimulus(1'b0, 1'b0);
    tick(40);
    base = pulseCount;
    applyStimulus(1'b1, 1'b0);
    pushId();
    waitPulses(base + 10, 1000);
    tick(40);
    applyStimulus(1'b0, 1'b0);
    checkOutput("restart_count", 32'(pulseCount - base), 32'd10);
    checkOutput("restart_drained", 32'(expQ.size()), 32'd0);

`ifdef TRIG_DEBOUNCE_EN
    // A short glitch never reaches the edge detector.
    tick(40);
    base = pulseCount;
    applyStimulus(1'b1, 1'b0);
    tick(5);
    applyStimulus(1'b0, 1'b0);
    tick(60);
    checkOutput("glitch_ignored", 32'(pulseCount - base), 32'd0);

    // A 20-cycle press sends once with the debounced latency.
    base = pulseCount;
    applyStimulus(1'b1, 1'b0);
    pushId();
    tick(20);
    applyStimulus(1'b0, 1'b0);
    waitPulses(base + 10, 1000);
    tick(40);
    checkOutput("press20_count", 32'(pulseCount - base), 32'd10);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
